// File: rtl/led_code_sequencer.sv
// ============================================================================
// led_code_sequencer
//
// Drives a single status LED with blink codes for the W5300 bring-up error
// flags. Each active-low error request is synchronized, latched as a sticky
// flag, and served round-robin. Source i is shown as i+1 pulses followed by a
// long dark gap. All timing is expressed in ticks of TICK_CYCLES clocks.
//
// Ports:
//   clk         board clock (50 MHz)
//   rst_n       asynchronous, active-low reset
//   err_n       active-low error requests, asynchronous to clk
//   clr_sticky  single-cycle pulse clearing all sticky flags
//   code_led    LED drive, 1 = lit
//   busy        high while a code is being emitted
//   cur_src     index of the source being emitted (holds when idle)
//   sticky      latched error flags
// ============================================================================
module led_code_sequencer #(
    parameter int N_SRC       = 3,
    parameter int TICK_CYCLES = 5_000_000,
    parameter int ON_TICKS    = 2,
    parameter int OFF_TICKS   = 2,
    parameter int GAP_TICKS   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_SRC-1:0] err_n,
    input  logic             clr_sticky,
    output logic             code_led,
    output logic             busy,
    output logic [1:0]       cur_src,
    output logic [N_SRC-1:0] sticky
);

    // Counters for pulses and phases must hold the largest of these values.
    localparam int MAX_AB = (N_SRC > ON_TICKS) ? N_SRC : ON_TICKS;
    localparam int MAX_CD = (OFF_TICKS > GAP_TICKS) ? OFF_TICKS : GAP_TICKS;
    localparam int MAXV   = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CW     = $clog2(MAXV + 1);

    localparam logic [1:0]  LAST_IDX = 2'(N_SRC - 1);
    localparam logic [31:0] TICK_END = 32'(TICK_CYCLES - 1);
    localparam logic [CW-1:0] ON_END  = CW'(ON_TICKS - 1);
    localparam logic [CW-1:0] OFF_END = CW'(OFF_TICKS - 1);
    localparam logic [CW-1:0] GAP_END = CW'(GAP_TICKS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ON,
        ST_OFF,
        ST_GAP
    } state_t;

    logic [N_SRC-1:0] err_meta;
    logic [N_SRC-1:0] err_sync;
    logic [N_SRC-1:0] err;
    logic [N_SRC-1:0] sticky_q;
    logic [31:0]      tick_cnt;
    logic             tick;

    state_t           state, state_d;
    logic [CW-1:0]    phase_cnt, phase_d;
    logic [CW-1:0]    pulses_left, pulses_d;
    logic [CW-1:0]    pulses_dec;
    logic [1:0]       cur_q, cur_d;
    logic [1:0]       last_served, last_d;
    logic             found;
    logic [1:0]       sel_idx;
    logic [1:0]       cand;

    // Two-flop synchronizer. Flops reset to the inactive (high) level so that
    // reset release never looks like an error request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_meta <= '1;
            err_sync <= '1;
        end else begin
            err_meta <= err_n;
            err_sync <= err_meta;
        end
    end

    assign err = ~err_sync;

    // Sticky flags: clear first, then OR in live errors so a simultaneous
    // error on a bit survives the clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= (clr_sticky ? '0 : sticky_q) | err;
        end
    end

    assign sticky = sticky_q;

    // Free-running tick timebase.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + 32'd1;
        end
    end

    assign tick = (tick_cnt == TICK_END);

    // Round-robin pick: scan upward from the source after the last one served,
    // wrapping around, and take the first sticky bit found.
    always_comb begin
        found   = 1'b0;
        sel_idx = last_served;
        cand    = '0;
        for (int k = 1; k <= N_SRC; k++) begin
            cand = 2'((int'(last_served) + k) % N_SRC);
            if (!found && sticky_q[cand]) begin
                found   = 1'b1;
                sel_idx = cand;
            end
        end
    end

    assign pulses_dec = pulses_left - CW'(1);

    // State register, with LED and busy registered from the next state so
    // they change in the cycle after the transitioning tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            phase_cnt   <= '0;
            pulses_left <= '0;
            cur_q       <= LAST_IDX;
            last_served <= LAST_IDX;
            code_led    <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= state_d;
            phase_cnt   <= phase_d;
            pulses_left <= pulses_d;
            cur_q       <= cur_d;
            last_served <= last_d;
            code_led    <= (state_d == ST_ON);
            busy        <= (state_d != ST_IDLE);
        end
    end

    assign cur_src = cur_q;

    // Next-state logic. Nothing moves except on a tick; the phase counter
    // counts ticks spent in the current state and restarts on every change.
    always_comb begin
        state_d  = state;
        phase_d  = phase_cnt;
        pulses_d = pulses_left;
        cur_d    = cur_q;
        last_d   = last_served;
        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        cur_d    = sel_idx;
                        last_d   = sel_idx;
                        pulses_d = CW'(int'(sel_idx) + 1);
                        phase_d  = '0;
                        state_d  = ST_ON;
                    end
                end
                ST_ON: begin
                    if (phase_cnt == ON_END) begin
                        phase_d  = '0;
                        pulses_d = pulses_dec;
                        state_d  = (pulses_dec != '0) ? ST_OFF : ST_GAP;
                    end else begin
                        phase_d = phase_cnt + CW'(1);
                    end
                end
                ST_OFF: begin
                    if (phase_cnt == OFF_END) begin
                        phase_d = '0;
                        state_d = ST_ON;
                    end else begin
                        phase_d = phase_cnt + CW'(1);
                    end
                end
                ST_GAP: begin
                    if (phase_cnt == GAP_END) begin
                        phase_d = '0;
                        state_d = ST_IDLE;
                    end else begin
                        phase_d = phase_cnt + CW'(1);
                    end
                end
                default: begin
                    phase_d = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule
